// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and helpers for the activation datapath.
//   FP_WIDTH         - IEEE-754 single-precision word width
//   NUM_REQ_DEFAULT  - default number of requesters sharing one Tanh unit
//   LATENCY_DEFAULT  - default act_x -> act_y latency of the Tanh unit
//   id_width()       - width of a requester index (at least one bit)
package cnn_pkg;

  localparam int FP_WIDTH        = 32;
  localparam int NUM_REQ_DEFAULT = 4;
  localparam int LATENCY_DEFAULT = 1;

  // A single requester still needs a 1-bit id so that ports never collapse to zero width.
  function automatic int id_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant.
//   req  [NUM_REQ-1:0] - request vector
//   ptr  [ID_W-1:0]    - highest-priority index this cycle
//   gnt  [NUM_REQ-1:0] - one-hot grant to the first request at or after ptr
//                        (wrapping); all zero when nothing is requested
module rr_arbiter
  import cnn_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt
);

  // Scan requesters starting at ptr, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    int          idx_s;
    logic [ID_W-1:0] sel_s;
    logic        found_s;
    gnt     = '0;
    found_s = 1'b0;
    idx_s   = 0;
    sel_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = int'(ptr) + k;
      if (idx_s >= NUM_REQ) begin
        idx_s = idx_s - NUM_REQ;
      end else begin
        idx_s = idx_s;
      end
      sel_s = idx_s[ID_W-1:0];
      if (!found_s && req[sel_s]) begin
        gnt[sel_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/activation_scheduler.sv
// activation_scheduler: shares one external pipelined Tanh unit among
// NUM_REQ requesters with round-robin arbitration and a tag pipeline that
// returns each result with the id of the requester that issued it.
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   req_valid/req_data  - per-requester operand valid / flattened operands
//   req_ready           - one-hot grant (combinational), zero with no request
//   act_x / act_y       - registered operand to / result from the Tanh unit
//   res_valid/data/id   - result strobe, value (act_y), owning requester
//   busy                - high while any operation is in flight
module activation_scheduler
  import cnn_pkg::*;
#(
  parameter  int DATA_WIDTH = FP_WIDTH,
  parameter  int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter  int LATENCY    = LATENCY_DEFAULT,
  localparam int ID_W       = id_width(NUM_REQ),
  localparam int CNT_W      = $clog2(LATENCY + 2)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         act_x,
  input  logic [DATA_WIDTH-1:0]         act_y,
  output logic                          res_valid,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]               res_id,
  output logic                          busy
);

  logic [NUM_REQ-1:0]    arb_req_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [ID_W-1:0]       gnt_idx_s;
  logic                  xfer_s;

  logic [ID_W-1:0]       rr_ptr_q,   rr_ptr_d;
  logic [DATA_WIDTH-1:0] act_x_q,    act_x_d;
  logic [LATENCY:0]      tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]       tag_id_q [LATENCY+1];
  logic [ID_W-1:0]       tag_id_d [LATENCY+1];
  logic [CNT_W-1:0]      inflight_q, inflight_d;

  // No grant is offered while reset is applied, so nothing can be accepted then.
  always_comb begin
    if (reset) begin
      arb_req_s = '0;
    end else begin
      arb_req_s = req_valid;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req (arb_req_s),
    .ptr (rr_ptr_q),
    .gnt (gnt_s)
  );

  // The grant is only ever raised on a valid lane, so any grant is a transfer.
  assign req_ready = gnt_s;
  assign xfer_s    = |gnt_s;

  // Encode the one-hot grant into a requester index.
  always_comb begin
    gnt_idx_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_s[k]) begin
        gnt_idx_s = ID_W'(k);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  // Next pointer and operand: advance past the winner on a transfer, else hold.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    act_x_d  = act_x_q;
    if (xfer_s) begin
      act_x_d = req_data[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
      if (int'(gnt_idx_s) == NUM_REQ - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + ID_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
      act_x_d  = act_x_q;
    end
  end

  // Tag pipeline: stage 0 lines up with act_x, stage LATENCY with act_y.
  always_comb begin
    tag_valid_d    = '0;
    tag_valid_d[0] = xfer_s;
    tag_id_d[0]    = gnt_idx_s;
    for (int k = 1; k <= LATENCY; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1];
      tag_id_d[k]    = tag_id_q[k-1];
    end
  end

  // Inflight count: issue adds one, retire removes one, both together hold.
  always_comb begin
    case ({xfer_s, tag_valid_q[LATENCY]})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      act_x_q     <= '0;
      tag_valid_q <= '0;
      inflight_q  <= '0;
      for (int k = 0; k <= LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      act_x_q     <= act_x_d;
      tag_valid_q <= tag_valid_d;
      inflight_q  <= inflight_d;
      for (int k = 0; k <= LATENCY; k++) begin
        tag_id_q[k] <= tag_id_d[k];
      end
    end
  end

  assign act_x     = act_x_q;
  assign res_valid = tag_valid_q[LATENCY];
  assign res_id    = tag_id_q[LATENCY];
  assign res_data  = act_y;
  assign busy      = (inflight_q != '0);

endmodule

// File: doc/activation_scheduler.md
ACTIVATION_SCHEDULER -- requirements
Module: activation_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the IEEE-754 single-precision operand/result width.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one Tanh unit.
REQ-003 The block SHALL have parameter LATENCY, default 1, meaning the cycles from act_x to a valid act_y in the Tanh unit.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ, per-requester operand valid.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, flattened operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ, one-hot grant; it is zero when there is no request.
REQ-009 The block SHALL have port act_x, output, DATA_WIDTH, the registered operand driven to the Tanh unit.
REQ-010 The block SHALL have port act_y, input, DATA_WIDTH, the Tanh unit result.
REQ-011 The block SHALL have port res_valid, output, 1, result strobe.
REQ-012 The block SHALL have port res_data, output, DATA_WIDTH, the result value, equal to act_y.
REQ-013 The block SHALL have port res_id, output, clog2(NUM_REQ), the index of the requester that owns the result.
REQ-014 The block SHALL have port busy, output, 1, high while any operation is in flight.

Function
REQ-015 Arbitration SHALL be round-robin: the grant goes to the first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ; req_ready is combinational from req_valid and rr_ptr.
REQ-016 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; at most one transfer occurs per cycle.
REQ-017 After a transfer from requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no transfer, rr_ptr SHALL hold.
REQ-018 On a transfer in cycle t, act_x SHALL present req_data[i] from cycle t+1; with no transfer, act_x SHALL hold its last value.
REQ-019 The tag pipeline (valid plus id, depth 1+LATENCY) SHALL assert res_valid in cycle t+1+LATENCY, with res_id=i and res_data=act_y that cycle.
REQ-020 Issue SHALL be fully pipelined: back-to-back transfers SHALL produce back-to-back res_valid in issue order, with no bubbles.
REQ-021 The result port SHALL have no backpressure; a consumer SHALL sample res_valid and res_id every cycle.
REQ-022 An inflight counter, 0 to 1+LATENCY, SHALL increment on issue and decrement on res_valid; on simultaneous issue and retire it SHALL hold; busy = (inflight != 0).
REQ-023 A requester deasserting req_valid without a grant SHALL lose nothing and SHALL NOT move rr_ptr.

Reset
REQ-024 While reset is high at a clock edge: rr_ptr=0, the tag pipeline is cleared, inflight=0, act_x=0; as a result res_valid=0, res_id=0, busy=0 and req_ready=0.
REQ-025 Reset mid-operation SHALL discard every in-flight tag; no res_valid SHALL appear for operands issued before reset.

Structure
REQ-026 The width, the default NUM_REQ and LATENCY values, and the id-width function SHALL be kept in the shared package cnn_pkg.
REQ-027 The round-robin grant logic SHALL be a single sub-module, rr_arbiter (inputs: request vector, pointer; output: one-hot grant).
REQ-028 The Tanh unit SHALL be outside this block, connected via act_x and act_y.

Verification
REQ-029 The bench SHALL use a Tanh model with LATENCY=1 and act_y = f(act_x).
REQ-030 Single request: req_valid=0001, data 0x3F000000 (0.5) -> req_ready=0001; act_x=0x3F000000 next cycle; res_valid, res_id=0 and res_data=f(0x3F000000) two cycles after the transfer.
REQ-031 All four requesters held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; res_id follows the same order two cycles later; res_valid is continuous.
REQ-032 req_valid=1010 with rr_ptr=0 -> grant 1, then 3, then 1; rr_ptr wraps correctly.
REQ-033 Reset asserted one cycle after a transfer of 0xBF000000 (-0.5) -> no res_valid for that operand; busy=0 and act_x=0 after reset.
REQ-034 Simultaneous issue and retire over 5 back-to-back operands -> inflight stays at 2 during steady state; busy drops one cycle after the last res_valid.
